// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map is indexed [row][col] as wired on the board.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE_PRESS,
      HELD,
      DEBOUNCE_RELEASE
   } scan_state_t;

   localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   localparam logic [3:0] COL_IDLE = 4'b1110;

   // True when exactly one row line is pulled low.
   function automatic logic one_low(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) ||
             (v == 4'b1011) || (v == 4'b0111);
   endfunction

   function automatic logic [1:0] low_idx(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_debounce_row_sync.sv
// Two-flop synchronizer for the raw keypad row lines.
// Resets to all-high, matching the idle pulled-up rows.
module keypad_row_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 4'hF;
         q    <= 4'hF;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with press/release debounce.
// Emits one key_valid pulse per accepted key with its hex code.
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 48_000,
   parameter int DEBOUNCE_CYCLES = 960_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int MAX_C = (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
                          SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CW = $clog2(MAX_C);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

   scan_state_t   state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [3:0]    col_d;
   logic [1:0]    col_idx, col_idx_d;
   logic [1:0]    row_idx, row_idx_d;
   logic [3:0]    code_d;
   logic          valid_d, held_d;
   logic [3:0]    rows_s;
   logic          row_hi;

   keypad_row_sync u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (row),
      .q     (rows_s)
   );

   assign row_hi = rows_s[row_idx];

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      col_d     = col;
      col_idx_d = col_idx;
      row_idx_d = row_idx;
      code_d    = key_code;
      valid_d   = 1'b0;
      held_d    = key_held;
      unique case (state)
         SCAN: begin
            if (cnt == SCAN_LAST) begin
               cnt_d = '0;
               if (one_low(rows_s)) begin
                  state_d   = DEBOUNCE_PRESS;
                  row_idx_d = low_idx(rows_s);
               end else begin
                  col_d     = {col[2:0], col[3]};
                  col_idx_d = col_idx + 2'd1;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DEBOUNCE_PRESS: begin
            // A bounce back high abandons this column entirely.
            if (row_hi) begin
               state_d   = SCAN;
               cnt_d     = '0;
               col_d     = {col[2:0], col[3]};
               col_idx_d = col_idx + 2'd1;
            end else if (cnt == DEB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               valid_d = 1'b1;
               held_d  = 1'b1;
               code_d  = KEY_MAP[row_idx][col_idx];
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         HELD: begin
            if (row_hi) begin
               state_d = DEBOUNCE_RELEASE;
               cnt_d   = '0;
            end
         end
         DEBOUNCE_RELEASE: begin
            if (!row_hi) begin
               state_d = HELD;
            end else if (cnt == DEB_LAST) begin
               state_d   = SCAN;
               cnt_d     = '0;
               held_d    = 1'b0;
               col_d     = {col[2:0], col[3]};
               col_idx_d = col_idx + 2'd1;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SCAN;
         cnt       <= '0;
         col       <= COL_IDLE;
         col_idx   <= 2'd0;
         row_idx   <= 2'd0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         col       <= col_d;
         col_idx   <= col_idx_d;
         row_idx   <= row_idx_d;
         key_code  <= code_d;
         key_valid <= valid_d;
         key_held  <= held_d;
      end
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a cycle model
// of the keypad, synchronizer lag and scan/debounce rules.
module tb_keypad_scan_debounce;

   localparam int SC = 4;
   localparam int DB = 8;
   localparam int PH_SCAN = 0;
   localparam int PH_PRESS = 1;
   localparam int PH_HELD = 2;
   localparam int PH_REL = 3;

   logic       clk;
   logic       reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] pressed = '0;
   logic        cmp_en = 1'b0;
   int          ntests = 0;
   int          nfail = 0;
   int          pulses = 0;
   logic [3:0]  last_code = 4'h0;

   int         m_ph = PH_SCAN;
   int         m_c = 0;
   int         m_r = 0;
   int         m_age = 0;
   logic [3:0] m_code = 4'h0;
   logic       m_valid = 1'b0;
   logic       m_held = 1'b0;
   logic [3:0] h1 = 4'hF;
   logic [3:0] h2 = 4'hF;

   keypad_scan_debounce #(
      .SCAN_CYCLES     (SC),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
   end

   function automatic logic [3:0] keypad(input int c);
      logic [3:0] v;
      v = 4'hF;
      for (int r = 0; r < 4; r++)
         if (pressed[r*4+c]) v[r] = 1'b0;
      return v;
   endfunction

   function automatic logic [3:0] colv(input int c);
      logic [3:0] v;
      v = 4'hF;
      v[c] = 1'b0;
      return v;
   endfunction

   function automatic logic [3:0] hexkey(input int r, input int c);
      string m;
      int    v;
      m = "123A456B789CE0FD";
      v = int'(m[r*4+c]);
      return (v >= 65) ? 4'(v - 55) : 4'(v - 48);
   endfunction

   // Behavioural model: phases, ages in cycles, 2-cycle row lag.
   always @(posedge clk or negedge reset) begin
      logic [3:0] rin;
      int nz;
      int zi;
      if (!reset) begin
         m_ph = PH_SCAN; m_c = 0; m_r = 0; m_age = 0;
         m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
         h1 = 4'hF; h2 = 4'hF;
      end else begin
         rin = keypad(m_c);
         m_valid = 1'b0;
         case (m_ph)
            PH_SCAN: begin
               if (m_age == SC - 1) begin
                  nz = 0; zi = 0;
                  for (int i = 0; i < 4; i++)
                     if (!h2[i]) begin nz++; zi = i; end
                  if (nz == 1) begin m_ph = PH_PRESS; m_r = zi; end
                  else m_c = (m_c + 1) % 4;
                  m_age = 0;
               end else m_age++;
            end
            PH_PRESS: begin
               if (h2[m_r]) begin
                  m_ph = PH_SCAN; m_c = (m_c + 1) % 4; m_age = 0;
               end else if (m_age == DB - 1) begin
                  m_ph = PH_HELD; m_valid = 1'b1; m_held = 1'b1;
                  m_code = hexkey(m_r, m_c);
               end else m_age++;
            end
            PH_HELD: begin
               if (h2[m_r]) begin m_ph = PH_REL; m_age = 0; end
            end
            default: begin
               if (!h2[m_r]) m_ph = PH_HELD;
               else if (m_age == DB - 1) begin
                  m_ph = PH_SCAN; m_held = 1'b0;
                  m_c = (m_c + 1) % 4; m_age = 0;
               end else m_age++;
            end
         endcase
         h2 = h1;
         h1 = rin;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         ntests++;
         if ({col, key_code, key_valid, key_held} !==
             {colv(m_c), m_code, m_valid, m_held}) begin
            nfail++;
            $display("FAIL model t=%0t col=%b/%b code=%h/%h valid=%b/%b held=%b/%b",
                     $time, col, colv(m_c), key_code, m_code,
                     key_valid, m_valid, key_held, m_held);
         end
      end
   end

   always @(posedge clk) begin
      if (reset && key_valid) begin
         pulses++;
         last_code = key_code;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_key(input int r, input int c, input logic v);
      pressed[r*4+c] = v;
   endtask

   task automatic wait_pulse(input string name, input int limit);
      int k;
      k = 0;
      while (k < limit && !key_valid) begin tick(1); k++; end
      ntests++;
      if (!key_valid) begin
         nfail++;
         $display("FAIL %s timeout got=none want=pulse", name);
      end
   endtask

   task automatic wait_phase(input string name, input int ph, input int limit);
      int k;
      k = 0;
      while (k < limit && m_ph != ph) begin tick(1); k++; end
      ntests++;
      if (m_ph != ph) begin
         nfail++;
         $display("FAIL %s timeout got=%0d want=%0d", name, m_ph, ph);
      end
   endtask

   initial begin
      int p0;
      logic [3:0] seq [0:3];
      seq[0] = 4'b1110; seq[1] = 4'b1101;
      seq[2] = 4'b1011; seq[3] = 4'b0111;
      reset = 1'b0;
      tick(3);
      check("rst_col", int'(col), 'he);
      check("rst_code", int'(key_code), 0);
      check("rst_valid", int'(key_valid), 0);
      check("rst_held", int'(key_held), 0);
      cmp_en = 1'b1;
      reset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         check("scan_col", int'(col), int'(seq[(k / 4) % 4]));
         tick(1);
      end

      // clean '5'
      p0 = pulses;
      set_key(1, 1, 1'b1);
      wait_pulse("five_pulse", 60);
      tick(40);
      check("five_held", int'(key_held), 1);
      check("five_col_frozen", int'(col), 'hd);
      set_key(1, 1, 1'b0);
      tick(13);
      check("five_col_next", int'(col), 'hb);
      check("five_released", int'(key_held), 0);
      check("five_count", pulses - p0, 1);
      check("five_code", int'(last_code), 5);

      // bounced '9'
      p0 = pulses;
      for (int i = 0; i < 8; i++) begin
         set_key(2, 2, (i % 2) == 0);
         tick(3);
      end
      set_key(2, 2, 1'b1);
      wait_pulse("nine_pulse", 80);
      tick(20);
      for (int i = 0; i < 8; i++) begin
         set_key(2, 2, (i % 2) == 1);
         tick(3);
      end
      set_key(2, 2, 1'b0);
      tick(30);
      check("nine_count", pulses - p0, 1);
      check("nine_code", int'(last_code), 9);
      check("nine_released", int'(key_held), 0);

      // short glitch on 'D'
      p0 = pulses;
      set_key(3, 3, 1'b1);
      wait_phase("d_capture", PH_PRESS, 40);
      tick(5);
      set_key(3, 3, 1'b0);
      tick(3);
      check("d_resume_col", int'(col), 'he);
      tick(20);
      check("d_count", pulses - p0, 0);
      check("d_code_kept", int'(key_code), 9);

      // '1' and '4' share a column
      p0 = pulses;
      set_key(0, 0, 1'b1);
      set_key(1, 0, 1'b1);
      tick(40);
      set_key(0, 0, 1'b0);
      set_key(1, 0, 1'b0);
      tick(10);
      check("dual_count", pulses - p0, 0);

      // hold 'A', then '0'
      p0 = pulses;
      set_key(0, 3, 1'b1);
      wait_pulse("a_pulse", 60);
      set_key(3, 1, 1'b1);
      tick(30);
      check("a_only_count", pulses - p0, 1);
      check("a_code", int'(last_code), 'ha);
      set_key(0, 3, 1'b0);
      tick(1);
      wait_pulse("zero_pulse", 80);
      tick(2);
      check("zero_count", pulses - p0, 2);
      check("zero_code", int'(last_code), 0);
      set_key(3, 1, 1'b0);
      tick(30);

      // reset during debounce of '7'
      p0 = pulses;
      set_key(2, 0, 1'b1);
      wait_phase("seven_capture", PH_PRESS, 40);
      tick(3);
      reset = 1'b0;
      #1;
      check("mid_rst_col", int'(col), 'he);
      check("mid_rst_code", int'(key_code), 0);
      check("mid_rst_valid", int'(key_valid), 0);
      check("mid_rst_held", int'(key_held), 0);
      set_key(2, 0, 1'b0);
      tick(3);
      reset = 1'b1;
      tick(30);
      check("seven_count", pulses - p0, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time and watching the four row lines.
- Debounces both press and release, then emits a single-cycle key_valid pulse with a 4-bit hex key code.
- Sits directly upstream of the keypress storage / seven-segment display path and replaces the separate column driver, mapper and jitter stages with one registered stage.

Parameters:
- SCAN_CYCLES, 48_000, clk cycles each column is driven before its rows are sampled (1 ms at 48 MHz).
- DEBOUNCE_CYCLES, 960_000, clk cycles a press or release must be continuously stable to be accepted (20 ms at 48 MHz).

Ports:
- clk  input  1  system clock, 48 MHz HSOSC.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  raw keypad row lines, pulled up; 0 means the key in the driven column is pressed.
- col  output  4  column drive, one-cold: exactly one bit is 0 at all times.
- key_code  output  4  hex value of the last accepted key; held until the next accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while an accepted key remains pressed, through the release debounce.

Behaviour:
- Reset (reset=0, asynchronous):
  - col=4'b1110, key_code=4'h0, key_valid=0, key_held=0.
  - State is SCAN; all counters are 0; the row synchronizer is 4'b1111.
- Row synchronization: 2-flop synchronizer. rows_s lags row by 2 cycles. All decisions use rows_s.
- Key map, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- SCAN state:
  - The dwell counter counts 0..SCAN_CYCLES-1, then col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Sampling happens on the last dwell cycle only.
  - If exactly one bit of rows_s is 0, latch the column and row indices and go to DEBOUNCE_PRESS. col is frozen.
  - If zero bits, or two or more bits, are 0, keep rotating. Multi-key presses in one column are ignored.
- DEBOUNCE_PRESS state:
  - The debounce counter starts at 0 on entry.
  - If the latched row reads 1 on any cycle, go to SCAN with no pulse. Scanning resumes at the next column.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low, the next cycle has state=HELD, key_valid=1, key_code=map[row][col] and key_held=1.
  - key_valid therefore asserts exactly DEBOUNCE_CYCLES cycles after entry.
- HELD state:
  - col stays frozen; only the latched row is watched. Other keys are ignored.
  - When the latched row reads 1, go to DEBOUNCE_RELEASE and clear the counter.
- DEBOUNCE_RELEASE state:
  - If the latched row reads 0, return to HELD with no new pulse.
  - After DEBOUNCE_CYCLES consecutive high cycles: key_held=0, go to SCAN, and col advances to the next column.
- key_valid is high for exactly 1 cycle per accepted press and never in any other state.
- Counters are sized $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)). Both parameters must be >= 2.
- A reset mid-operation aborts immediately: no pending pulse is emitted, and the reset values apply.

Decomposition:
- keypad_pkg holds:
  - the state enum, scan_state_t {SCAN, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE};
  - the KEY_MAP constant, logic [3:0] [0:3][0:3];
  - the COL_IDLE constant, 4'b1110.
- One sub-module, keypad_row_sync: a 4-bit 2-flop synchronizer with asynchronous active-low reset to 4'b1111.
- The FSM, counters and map lookup live in keypad_scan_debounce.

Test Plan:
- Bench parameters: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8. The keypad model sets row[r]=0 iff col[c]=0 and key (r,c) is pressed.
- Reset, no keys:
  - During reset: col=1110, key_code=0, key_valid=0, key_held=0.
  - After release: col steps 1110, 1101, 1011, 0111, 1110, each for 4 cycles.
- Clean press of '5' (r1,c1), held 40 cycles:
  - Exactly one key_valid pulse, with key_code=4'h5.
  - key_held=1 from the pulse until 8 cycles after release.
  - col stays 1101 throughout, then advances to 1011.
- Bounced press of '9' (r2,c2):
  - Toggle the key every 3 cycles for 24 cycles, then hold.
  - Exactly one pulse, key_code=4'h9, and no extra pulses during release bounce.
- Glitch:
  - Press 'D' (r3,c3) for 5 cycles after capture.
  - No pulse; key_code keeps its previous value; scanning resumes at col 1110.
- Conflicts:
  - Press '1' and '4' together (same column): no pulse.
  - Hold 'A', then press '0': only the 4'hA pulse occurs.
  - After 'A' is released and debounced, '0' is captured and gives key_code=4'h0.
- Reset mid-DEBOUNCE_PRESS:
  - Assert reset 3 cycles into the debounce of '7'.
  - All outputs take their reset values, and no key_valid occurs.
